// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle 32-bit divide sequencer for the EX stage.
//
// Accepts a DIV/DIVU request and runs a 32-step restoring division, one step
// per clock. While the divide is in flight it requests a pipeline stall. When
// it finishes it returns {remainder, quotient} for writing into HI/LO. A flush
// (annul_i) abandons a divide that is in progress.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous reset, active low
//   start_i      in   divide request; held high until ready_o is seen
//   annul_i      in   abandon the current or incoming divide
//   signed_i     in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    in   dividend, sampled only on acceptance
//   opdata2_i    in   divisor, sampled only on acceptance
//   result_o     out  {remainder[63:32], quotient[31:0]}, registered
//   ready_o      out  result_o is valid, registered
//   stall_req_o  out  combinational stall request
// -----------------------------------------------------------------------------
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  // {partial_rem[63:32], dividend_shift[31:0]}. Bit 64 of the 65-bit working
  // value exists only transiently after the shift, so it is not stored.
  logic [63:0] work_reg, work_next;
  logic [31:0] dvs_reg, dvs_next;        // divisor magnitude
  logic        neg1_reg, neg1_next;      // dividend was negative (signed op)
  logic        neg2_reg, neg2_next;      // divisor was negative (signed op)
  logic        signed_reg, signed_next;
  logic [63:0] result_reg, result_next;
  logic        ready_reg, ready_next;

  // Datapath for one restoring step.
  logic [64:0] step_shift;
  logic [32:0] step_diff;
  logic [63:0] step_work;
  logic [31:0] quot_raw, rem_raw, quot_fix, rem_fix;
  logic [31:0] mag1, mag2;

  always_comb begin
    step_shift = {work_reg, 1'b0};
    step_diff  = step_shift[64:32] - {1'b0, dvs_reg};
    // A borrow out of the 33-bit trial subtraction means the divisor did not
    // fit: restore by keeping the shifted value (quotient bit 0).
    if (step_diff[32]) begin
      step_work = step_shift[63:0];
    end else begin
      step_work = {step_diff[31:0], step_shift[31:1], 1'b1};
    end

    quot_raw = step_work[31:0];
    rem_raw  = step_work[63:32];
    // Quotient is negative when the signs differ; remainder follows the
    // dividend. 0x80000000 / -1 wraps back to 0x80000000 naturally.
    quot_fix = (signed_reg && (neg1_reg ^ neg2_reg)) ? -quot_raw : quot_raw;
    rem_fix  = (signed_reg && neg1_reg) ? -rem_raw : rem_raw;

    mag1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  end

  // Next-state and output logic.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    dvs_next    = dvs_reg;
    neg1_next   = neg1_reg;
    neg2_next   = neg2_reg;
    signed_next = signed_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    case (state_reg)
      FREE: begin
        if (start_i && !annul_i) begin
          work_next   = {32'd0, mag1};
          dvs_next    = mag2;
          neg1_next   = signed_i & opdata1_i[31];
          neg2_next   = signed_i & opdata2_i[31];
          signed_next = signed_i;
          cnt_next    = 6'd0;
          state_next  = (opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        result_next = 64'd0;
        if (annul_i) begin
          state_next = FREE;
          ready_next = 1'b0;
        end else begin
          state_next = END;
          ready_next = 1'b1;
        end
      end

      ON: begin
        if (annul_i) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = 64'd0;
        end else begin
          work_next = step_work;
          cnt_next  = cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            state_next  = END;
            ready_next  = 1'b1;
            result_next = {rem_fix, quot_fix};
          end
        end
      end

      END: begin
        // EX holds start until it has consumed the result.
        if (!start_i) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = 64'd0;
        end
      end

      default: begin
        state_next  = FREE;
        ready_next  = 1'b0;
        result_next = 64'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FREE;
      cnt_reg    <= 6'd0;
      work_reg   <= 64'd0;
      dvs_reg    <= 32'd0;
      neg1_reg   <= 1'b0;
      neg2_reg   <= 1'b0;
      signed_reg <= 1'b0;
      result_reg <= 64'd0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      dvs_reg    <= dvs_next;
      neg1_reg   <= neg1_next;
      neg2_reg   <= neg2_next;
      signed_reg <= signed_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  assign result_o    = result_reg;
  assign ready_o     = ready_reg;
  assign stall_req_o = start_i & ~annul_i & (state_reg != END);

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq.
// Stimulus pushes the expected {remainder, quotient} and latency into a
// scoreboard queue; an independent monitor pops and compares on each rising
// edge of ready_o. Expected values come from plain integer division.
// -----------------------------------------------------------------------------
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: integer division truncating toward zero on 64-bit values.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = {{32{a[31]}}, a};
      lb = {{32{b[31]}}, b};
    end else begin
      la = {32'd0, a};
      lb = {32'd0, b};
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: compare whenever a result is presented.
  initial begin
    logic ready_prev;
    exp_t e;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o && !ready_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          $display("div a=%h b=%h signed=%0d result=%h expected=%h latency=%0d",
                   e.a, e.b, e.s, result_o, e.res, cyc - e.acc);
        end
      end else if (!ready_o) begin
        check("result_idle_zero", result_o, 64'd0);
      end
      ready_prev = ready_o;
    end
  end

  // Issue a divide in the current cycle (call just after a rising edge).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    bit seen;
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    e.res = ref_div(a, b, s);
    e.acc = cyc;
    e.lat = (b == 32'd0) ? 2 : 33;
    e.a = a;
    e.b = b;
    e.s = s;
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        check("stall_at_ready", {63'd0, stall_req_o}, 64'd0);
        break;
      end
      check("stall_busy", {63'd0, stall_req_o}, 64'd1);
      @(posedge clk);
      #1;
      // Operands are ignored after acceptance.
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_i  = 1'($urandom_range(0, 1));
    end
    if (!seen) check("ready_timeout", {63'd0, ready_o}, 64'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_drop", {63'd0, ready_o}, 64'd0);
    check("stall_idle", {63'd0, stall_req_o}, 64'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk);
    #1;
    run_div(a, b, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int sel;

    // Reset state.
    @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(32'h1234, 32'd0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(32'h8000_0000, 32'd0, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Annul in cycle 10; the new request in cycle 11 must be accepted at once.
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    check("stall_annul", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    run_div(32'd9, 32'd3, 1'b0);

    // Asynchronous reset in cycle 20 of a divide.
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'd5;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {63'd0, ready_o}, 64'd0);
    check("arst_result", result_o, 64'd0);
    check("arst_stall", {63'd0, stall_req_o}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_div(32'd12345, 32'd67, 1'b0);

    // Randomised divides.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin a = $urandom_range(0, 100); b = $urandom; end
        default: b = $urandom;
      endcase
      issue(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
